// File: rtl/uart_tx_ser_if.sv
// Producer-side bus into the UART serialiser: character push strobe,
// almost-full back-pressure and the bit-period setting.
interface uart_tx_ser_if;
  logic [7:0]  uart_io_char;
  logic        uart_io_we;
  logic        uart_io_full;
  logic [15:0] uart_term;

  modport master (output uart_io_char, output uart_io_we, output uart_term, input uart_io_full);
  modport slave  (input uart_io_char, input uart_io_we, input uart_term, output uart_io_full);
endinterface

// File: rtl/uart_tx_ser.sv
// UART 8N1 transmitter: 2**FIFO_AW-entry character FIFO feeding a bit serialiser.
// state | meaning
// IDLE  | line high, waiting for a queued character
// START | start bit (low) for term_lat cycles
// DATA  | eight data bits, LSB first, term_lat cycles each
// STOP  | stop bit (high); pops the next character back-to-back if one is queued
module uart_tx_ser #(
  parameter int FIFO_AW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  uart_tx_ser_if.slave io,
  output logic         uart_tx,
  output logic         tx_busy
);
  localparam int DEPTH = 2**FIFO_AW;
  localparam logic [FIFO_AW:0]   CNT_ONE    = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0]   CNT_DEPTH  = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ALMOST = (FIFO_AW+1)'(DEPTH-1);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [FIFO_AW:0]   count_nxt;
  logic               push;
  logic               pop;
  logic               fifo_ne;
  logic               full_q;

  logic [1:0]  state;
  logic [15:0] baud_cnt;
  logic [15:0] term_lat;
  logic [15:0] term_eff;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        tx_q;
  logic        bit_done;

  assign fifo_ne  = (count != '0);
  assign bit_done = (baud_cnt == term_lat - 16'd1);
  // Periods below 2 would leave no room for the counter to run; clamp them.
  assign term_eff = (io.uart_term < 16'd2) ? 16'd2 : io.uart_term;

  // Writes into a full FIFO are discarded; the almost-full flag keeps this rare.
  assign push = io.uart_io_we && (count != CNT_DEPTH);
  assign pop  = fifo_ne && ((state == IDLE) || ((state == STOP) && bit_done));

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + CNT_ONE;
    else if (pop && !push)
      count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      count  <= count_nxt;
      full_q <= (count_nxt >= CNT_ALMOST);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= io.uart_io_char;
  end

  // The line level is registered alongside the state so uart_tx never
  // depends combinationally on inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      term_lat <= 16'd2;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_q <= 1'b1;
          if (fifo_ne) begin
            shift    <= mem[rd_ptr];
            term_lat <= term_eff;
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= START;
            tx_q     <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx_q     <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx_q  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx_q    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (fifo_ne) begin
              shift    <= mem[rd_ptr];
              term_lat <= term_eff;
              bit_idx  <= '0;
              state    <= START;
              tx_q     <= 1'b0;
            end else begin
              state <= IDLE;
              tx_q  <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

  assign uart_tx         = tx_q;
  assign io.uart_io_full = full_q;
  assign tx_busy         = (state != IDLE) || fifo_ne;

endmodule

// File: tb/tb_uart_tx_ser.sv
// Bench for uart_tx_ser: a line monitor decodes each frame cycle-by-cycle
// against a queue of expected characters and bit periods.
module tb_uart_tx_ser;
  logic clk;
  logic rst_n;
  logic uart_tx;
  logic tx_busy;

  uart_tx_ser_if bus ();

  uart_tx_ser #(.FIFO_AW(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .io      (bus.slave),
    .uart_tx (uart_tx),
    .tx_busy (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ch;
    int         period;
    bit         b2b;
  } frame_t;

  typedef struct {
    logic [7:0]  ch;
    logic [15:0] term;
    int          period;
  } vec_t;

  frame_t exp_q[$];
  int checks;
  int errors;
  int rx_count;

  // Line monitor
  bit         mon_active;
  int         mon_cyc;
  int         idle_cnt;
  int         bad_cyc;
  frame_t     cur;
  logic [7:0] rx;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
      idle_cnt   = 0;
    end else begin
      if (!mon_active) begin
        if (uart_tx === 1'b0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: start bit seen at %0t, no character queued", $time);
            cur = '{8'h00, 2, 1'b0};
          end else begin
            cur = exp_q.pop_front();
            if (cur.b2b) begin
              checks++;
              if (idle_cnt != 0) begin
                errors++;
                $display("FAIL frame_gap: char %02h started after %0d idle cycles, required 0", cur.ch, idle_cnt);
              end
            end
          end
          mon_active = 1'b1;
          mon_cyc    = 0;
          bad_cyc    = 0;
          rx         = '0;
        end else begin
          idle_cnt++;
        end
      end
      if (mon_active) begin
        int   bidx;
        logic lvl;
        bidx = mon_cyc / cur.period;
        if (bidx == 0)      lvl = 1'b0;
        else if (bidx == 9) lvl = 1'b1;
        else                lvl = cur.ch[bidx-1];
        if (uart_tx !== lvl) bad_cyc++;
        if (bidx >= 1 && bidx <= 8 && (mon_cyc % cur.period) == cur.period / 2)
          rx[bidx-1] = uart_tx;
        if (mon_cyc == 10 * cur.period - 1) begin
          checks += 2;
          if (bad_cyc != 0) begin
            errors++;
            $display("FAIL frame_shape: char %02h period %0d had %0d wrong line cycles, required 0",
                     cur.ch, cur.period, bad_cyc);
          end
          if (rx !== cur.ch) begin
            errors++;
            $display("FAIL frame_data: decoded %02h, required %02h", rx, cur.ch);
          end
          rx_count++;
          mon_active = 1'b0;
          idle_cnt   = 0;
        end else begin
          mon_cyc++;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic push(input logic [7:0] c);
    bus.uart_io_char = c;
    bus.uart_io_we   = 1'b1;
    @(negedge clk);
    bus.uart_io_we   = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while ((tx_busy !== 1'b0 || mon_active) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_busy !== 1'b0 || mon_active) begin
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles", name, budget);
    end
  endtask

  vec_t vecs[5];

  initial begin
    int bad;
    int rx_before;

    vecs[0] = '{8'h55, 16'd4, 4};
    vecs[1] = '{8'h81, 16'd1, 2};
    vecs[2] = '{8'h00, 16'd0, 2};
    vecs[3] = '{8'hFF, 16'd2, 2};
    vecs[4] = '{8'hC3, 16'd7, 7};

    checks   = 0;
    errors   = 0;
    rx_count = 0;
    rst_n    = 1'b0;
    bus.uart_io_char = 8'h00;
    bus.uart_io_we   = 1'b0;
    bus.uart_term    = 16'd4;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: quiet after reset
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || bus.uart_io_full !== 1'b0 || tx_busy !== 1'b0) bad++;
    end
    check("reset_idle_bad_cycles", bad, 0);

    // 2: 0x55 at 4 cycles/bit, start bit one cycle after the push edge
    bus.uart_term = 16'd4;
    exp_q.push_back('{8'h55, 4, 1'b0});
    push(8'h55);
    check("latency_tx_before_pop", uart_tx, 1'b1);
    check("busy_after_push", tx_busy, 1'b1);
    @(negedge clk);
    check("latency_start_bit", uart_tx, 1'b0);
    bad = 0;
    for (int i = 2; i <= 40; i++) begin
      @(negedge clk);
      if (tx_busy !== 1'b1) bad++;
    end
    check("busy_during_frame_bad", bad, 0);
    @(negedge clk);
    check("busy_falls_after_frame", tx_busy, 1'b0);
    check("frame_0x55_received", rx_count, 1);

    // Table: one character per vector, period clamped for terms below 2
    for (int v = 0; v < 5; v++) begin
      rx_before = rx_count;
      bus.uart_term = vecs[v].term;
      exp_q.push_back('{vecs[v].ch, vecs[v].period, 1'b0});
      push(vecs[v].ch);
      wait_idle(200, "vec");
      check("vec_frame_count", rx_count - rx_before, 1);
    end

    // 3: two back-to-back frames at 3 cycles/bit
    rx_before = rx_count;
    bus.uart_term = 16'd3;
    exp_q.push_back('{8'hA5, 3, 1'b0});
    exp_q.push_back('{8'h3C, 3, 1'b1});
    push(8'hA5);
    push(8'h3C);
    wait_idle(200, "b2b");
    check("b2b_frame_count", rx_count - rx_before, 2);

    // 4: overfill; first frame at 5208, the rest shortened to keep the run brief
    rx_before = rx_count;
    bus.uart_term = 16'd5208;
    for (int k = 1; k <= 18; k++) begin
      if (k <= 17)
        exp_q.push_back('{8'(k), (k == 1) ? 5208 : 4, (k > 1)});
      push(8'(k));
      if (k == 2) bus.uart_term = 16'd4;
      if (k >= 14) check($sformatf("full_after_push_%0d", k), bus.uart_io_full, (k >= 16));
    end
    wait_idle(60000, "overfill");
    check("overfill_frame_count", rx_count - rx_before, 17);
    check("overfill_full_cleared", bus.uart_io_full, 1'b0);

    // 5: term change mid-frame applies to the next frame
    rx_before = rx_count;
    bus.uart_term = 16'd4;
    exp_q.push_back('{8'h0F, 4, 1'b0});
    push(8'h0F);
    repeat (18) @(negedge clk);
    bus.uart_term = 16'd8;
    exp_q.push_back('{8'hF0, 8, 1'b1});
    push(8'hF0);
    wait_idle(400, "term_change");
    check("term_change_frame_count", rx_count - rx_before, 2);

    // 6: asynchronous reset in the middle of data bit 2
    rx_before = rx_count;
    bus.uart_term = 16'd10;
    exp_q.push_back('{8'h5A, 10, 1'b0});
    exp_q.push_back('{8'h11, 10, 1'b1});
    exp_q.push_back('{8'h22, 10, 1'b1});
    push(8'h5A);
    push(8'h11);
    push(8'h22);
    repeat (32) @(negedge clk);
    check("mid_frame_bit2_low", uart_tx, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("async_reset_tx_high", uart_tx, 1'b1);
    check("async_reset_busy_low", tx_busy, 1'b0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || bus.uart_io_full !== 1'b0) bad++;
    end
    check("post_reset_quiet_bad", bad, 0);
    check("post_reset_no_frames", rx_count - rx_before, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
